// File: rtl/serial_pkg.sv
// Shared types for the RX packet buffer: write-FSM encoding,
// drop-counter width and slot-index width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FILL    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int idx_w(input int logsize);
        return (logsize > 0) ? logsize : 1;
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// Two packet banks with full flags, write/read bank pointers and
// the read slot pointer; a release frees its bank in the same cycle.
module pingpong_bank
    import serial_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LOGSIZE = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         wr_en_i,
    input  logic [idx_w(LOGSIZE)-1:0]    wr_slot_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         commit_i,
    input  logic                         rd_take_i,
    output logic                         wr_full_o,
    output logic                         rd_valid_o,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [idx_w(LOGSIZE)-1:0]    rd_ptr_o
);

    localparam int IW    = idx_w(LOGSIZE);
    localparam int DEPTH = 1 << LOGSIZE;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [1:0]       full_q, full_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic [IW-1:0]    rptr_q, rptr_d;
    logic             release_w;

    assign release_w = rd_take_i && (rptr_q == LAST);

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wbank_q][wr_slot_i] <= wr_data_i;
        end
    end

    // Release before commit: with one-slot packets both may hit one bank.
    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        rptr_d  = rptr_q;
        if (rd_take_i) begin
            rptr_d = release_w ? '0 : rptr_q + IW'(1);
        end
        if (release_w) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end
        if (commit_i) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            rptr_q  <= '0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            rptr_q  <= rptr_d;
        end
    end

    assign wr_full_o  = full_q[wbank_q] && !(release_w && (rbank_q == wbank_q));
    assign rd_valid_o = full_q[rbank_q];
    assign rd_data_o  = mem_q[rbank_q][rptr_q];
    assign rd_ptr_o   = rptr_q;

endmodule

// File: rtl/rx_packet_buffer.sv
// Ping-pong packet buffer between a frame receiver and a ready/valid consumer.
// Optional RX_PKTBUF_DROP_CNT_EN adds a saturating dropped_count output.
module rx_packet_buffer
    import serial_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LOGSIZE = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_sample_valid,
    input  logic [idx_w(LOGSIZE)-1:0]    in_index,
    input  logic                         in_frame_end,
    output logic [WIDTH-1:0]             out_data,
    output logic [idx_w(LOGSIZE)-1:0]    out_index,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic                         seq_error
`ifdef RX_PKTBUF_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]        dropped_count
`endif
);

    localparam int IW = idx_w(LOGSIZE);
    localparam logic [IW-1:0] LAST = IW'((1 << LOGSIZE) - 1);

    wr_state_e        state_q, state_d;
    logic [IW-1:0]    exp_q, exp_d;
    logic             ovf_q, ovf_d;
    logic             seq_q, seq_d;
    logic             wr_en, commit, take;
    logic             wr_full, rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [IW-1:0]    rd_ptr;
    logic             idx_zero;

    assign idx_zero = (in_index == '0);
    assign take     = rd_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WR_IDLE;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            ovf_q   <= ovf_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        if (in_sample_valid) begin
            unique case (state_q)
                WR_IDLE, WR_DISCARD: begin
                    if (idx_zero) begin
                        exp_d   = IW'(1);
                        state_d = in_frame_end ? WR_IDLE
                                : (wr_full ? WR_DISCARD : WR_FILL);
                    end else if (state_q == WR_DISCARD && in_frame_end) begin
                        state_d = WR_IDLE;
                    end
                end
                WR_FILL: begin
                    if (idx_zero) begin
                        exp_d = IW'(1);
                    end else if (in_index == exp_q) begin
                        if (in_frame_end) state_d = WR_IDLE;
                        else              exp_d   = exp_q + IW'(1);
                    end else begin
                        state_d = WR_IDLE;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        ovf_d  = 1'b0;
        seq_d  = 1'b0;
        if (in_sample_valid) begin
            unique case (state_q)
                WR_IDLE, WR_DISCARD: begin
                    if (idx_zero && !wr_full) begin
                        wr_en  = 1'b1;
                        commit = in_frame_end;
                    end else if (idx_zero) begin
                        ovf_d = 1'b1;
                    end
                end
                WR_FILL: begin
                    if (idx_zero) begin
                        wr_en = 1'b1;
                        seq_d = 1'b1;
                    end else if (in_index == exp_q) begin
                        wr_en  = 1'b1;
                        commit = in_frame_end;
                    end else begin
                        seq_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pingpong_bank #(
        .WIDTH   (WIDTH),
        .LOGSIZE (LOGSIZE)
    ) u_bank (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en_i    (wr_en),
        .wr_slot_i  (in_index),
        .wr_data_i  (in_data),
        .commit_i   (commit),
        .rd_take_i  (take),
        .wr_full_o  (wr_full),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_ptr_o   (rd_ptr)
    );

    // Bank contents are unreset, so data is masked until a packet is held.
    assign out_valid = rd_valid;
    assign out_data  = rd_valid ? rd_data : '0;
    assign out_index = rd_ptr;
    assign out_last  = rd_valid && (rd_ptr == LAST);
    assign overflow  = ovf_q;
    assign seq_error = seq_q;

`ifdef RX_PKTBUF_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
        end else if (ovf_d && drop_q != '1) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

    assign dropped_count = drop_q;
`endif

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Randomized and directed bench for rx_packet_buffer (WIDTH=16, LOGSIZE=1)
// against a queue-based packet model.
module tb_rx_packet_buffer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_sample_valid;
    logic [0:0]  in_index;
    logic        in_frame_end;
    logic [15:0] out_data;
    logic [0:0]  out_index;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        overflow;
    logic        seq_error;
`ifdef RX_PKTBUF_DROP_CNT_EN
    logic [15:0] dropped_count;
`endif

    always #5 clock = ~clock;

    rx_packet_buffer #(.WIDTH(16), .LOGSIZE(1)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_data         (in_data),
        .in_sample_valid (in_sample_valid),
        .in_index        (in_index),
        .in_frame_end    (in_frame_end),
        .out_data        (out_data),
        .out_index       (out_index),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .overflow        (overflow),
        .seq_error       (seq_error)
`ifdef RX_PKTBUF_DROP_CNT_EN
        ,
        .dropped_count   (dropped_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Model: committed packets as {word1, word0}; at most two held.
    logic [31:0] mq[$];
    int          rptr  = 0;
    int          mode  = 0;
    logic [15:0] part0 = '0;
    logic        eovf  = 1'b0;
    logic        eseq  = 1'b0;
    int          edrop = 0;

    task automatic model_step();
        if (!reset_n) begin
            mq.delete();
            rptr = 0; mode = 0; eovf = 0; eseq = 0; edrop = 0;
        end else begin
            eovf = 0;
            eseq = 0;
            if (mq.size() > 0 && out_ready) begin
                if (rptr == 1) begin
                    mq.delete(0);
                    rptr = 0;
                end else begin
                    rptr = rptr + 1;
                end
            end
            if (in_sample_valid) begin
                if (mode != 1) begin
                    if (in_index == 0) begin
                        if (mq.size() < 2) begin
                            part0 = in_data;
                            mode  = 1;
                        end else begin
                            eovf = 1;
                            if (edrop < 65535) edrop++;
                            mode = 2;
                        end
                    end else if (mode == 2 && in_frame_end) begin
                        mode = 0;
                    end
                end else if (in_index == 0) begin
                    eseq  = 1;
                    part0 = in_data;
                end else begin
                    mq.push_back({in_data, part0});
                    mode = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        model_step();
    end

    logic [15:0] got[$];
    int          ovf_seen = 0;
    int          seq_seen = 0;
    logic        pv = 0, pr = 0;
    logic [15:0] pd = '0;

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            chk("out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0][rptr*16 +: 16]);
                chk("out_index", out_index, rptr);
                chk("out_last", out_last, rptr == 1);
            end
            chk("overflow", overflow, eovf);
            chk("seq_error", seq_error, eseq);
`ifdef RX_PKTBUF_DROP_CNT_EN
            chk("dropped_count", dropped_count, edrop);
`endif
            if (pv && !pr && out_valid)
                chk("stall_hold", out_data, pd);
            if (out_valid && out_ready) got.push_back(out_data);
            if (overflow) ovf_seen++;
            if (seq_error) seq_seen++;
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
    end

    task automatic drv(input logic v, input logic [15:0] d,
                       input logic idx, input logic rdy);
        @(posedge clock);
        #2;
        in_sample_valid = v;
        in_data         = d;
        in_index        = idx;
        in_frame_end    = v && idx;
        out_ready       = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drv(1'b0, 16'h0, 1'b0, rdy);
    endtask

    task automatic chk_got(input string nm, input int n,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_len"}, got.size(), n);
        for (int i = 0; i < n; i++)
            chk({nm, "_word"}, (i < got.size()) ? {16'h0, got[i]} : 32'hDEADBEEF, e[i]);
    endtask

    int o0, s0, r, rp;

    initial begin
        reset_n = 0; in_data = '0; in_sample_valid = 0;
        in_index = '0; in_frame_end = 0; out_ready = 0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_seq_error", seq_error, 0);
`ifdef RX_PKTBUF_DROP_CNT_EN
        chk("rst_dropped", dropped_count, 0);
`endif
        @(posedge clock); #2; reset_n = 1;

        // Basic packet, valid on the cycle after frame end
        drv(1, 16'h1234, 0, 1);
        drv(1, 16'h5678, 1, 1);
        drv(0, 16'h0, 0, 1);
        @(negedge clock);
        chk("t1_valid", out_valid, 1);
        chk("t1_data0", out_data, 16'h1234);
        chk("t1_idx0", out_index, 0);
        chk("t1_last0", out_last, 0);
        @(negedge clock);
        chk("t1_data1", out_data, 16'h5678);
        chk("t1_idx1", out_index, 1);
        chk("t1_last1", out_last, 1);
        idle(2, 1);

        // Three packets with consumer stalled
        o0 = ovf_seen;
        drv(1, 16'hA000, 0, 0); drv(1, 16'hA001, 1, 0);
        drv(1, 16'hB000, 0, 0); drv(1, 16'hB001, 1, 0);
        drv(1, 16'hC000, 0, 0); drv(1, 16'hC001, 1, 0);
        idle(3, 0);
        chk("t2_ovf_pulses", ovf_seen - o0, 1);
`ifdef RX_PKTBUF_DROP_CNT_EN
        chk("t2_dropped", dropped_count, 1);
`endif
        got.delete();
        idle(8, 1);
        chk_got("t2", 4, 16'hA000, 16'hA001, 16'hB000, 16'hB001);

        // Resync restart
        s0 = seq_seen;
        got.delete();
        drv(1, 16'hAAAA, 0, 1);
        drv(1, 16'hBBBB, 0, 1);
        drv(1, 16'hCCCC, 1, 1);
        idle(4, 1);
        chk("t3_seq_pulses", seq_seen - s0, 1);
        chk_got("t3", 2, 16'hBBBB, 16'hCCCC, 16'h0, 16'h0);

        // Toggling ready
        drv(1, 16'hD000, 0, 0);
        drv(1, 16'hD001, 1, 0);
        got.delete();
        for (int i = 0; i < 8; i++) drv(0, 16'h0, 0, i[0]);
        chk_got("t4", 2, 16'hD000, 16'hD001, 16'h0, 16'h0);

        // Release and commit on the same cycle
        o0 = ovf_seen;
        got.delete();
        drv(1, 16'hE000, 0, 0);
        drv(1, 16'hE001, 1, 0);
        drv(1, 16'hF000, 0, 0);
        drv(0, 16'h0, 0, 1);
        drv(1, 16'hF001, 1, 1);
        idle(6, 1);
        chk("t5_ovf_pulses", ovf_seen - o0, 0);
        chk_got("t5", 4, 16'hE000, 16'hE001, 16'hF000, 16'hF001);

        // Reset mid-fill
        drv(1, 16'h1111, 0, 1);
        @(posedge clock); #2;
        reset_n = 0;
        in_sample_valid = 0;
        in_frame_end = 0;
        @(negedge clock);
        chk("t6_valid_in_rst", out_valid, 0);
        @(posedge clock); #2; reset_n = 1;
        got.delete();
        drv(1, 16'h2222, 0, 1);
        drv(1, 16'h3333, 1, 1);
        idle(4, 1);
        chk_got("t6", 2, 16'h2222, 16'h3333, 16'h0, 16'h0);

        // Random traffic, model checked every cycle
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 1000; k++) begin
                r  = $urandom_range(0, 99);
                rp = (ph == 0) ? 90 : (ph == 1) ? 30 : 60;
                if (r < 55) begin
                    drv(1, 16'($urandom), 0, $urandom_range(0, 99) < rp);
                    drv(1, 16'($urandom), 1, $urandom_range(0, 99) < rp);
                end else if (r < 70) begin
                    drv(1, 16'($urandom), 0, $urandom_range(0, 99) < rp);
                end else if (r < 80) begin
                    drv(1, 16'($urandom), 1, $urandom_range(0, 99) < rp);
                end else begin
                    drv(0, 16'h0, 0, $urandom_range(0, 99) < rp);
                end
            end
        end
        idle(10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_packet_buffer.md
RX_PACKET_BUFFER -- requirements
Module: rx_packet_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the sample width in bits.
REQ-002 The block SHALL have parameter LOGSIZE, default 1, so that one packet is 2^LOGSIZE samples.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_data, input, WIDTH: the received sample, valid while in_sample_valid is high.
REQ-006 Port in_sample_valid, input, 1: one-cycle pulse per completed sample from the frame receiver.
REQ-007 Port in_index, input, LOGSIZE: slot of the sample within its packet, qualified by in_sample_valid.
REQ-008 Port in_frame_end, input, 1: high together with in_sample_valid on the final sample (in_index all-ones).
REQ-009 Port out_data, output, WIDTH: the buffered sample presented to the consumer.
REQ-010 Port out_index, output, LOGSIZE: slot of out_data within its packet.
REQ-011 Port out_valid, output, 1: out_data/out_index/out_last are valid.
REQ-012 Port out_last, output, 1: out_data is the final sample of the packet.
REQ-013 Port out_ready, input, 1: consumer accepts; a transfer occurs on a cycle where out_valid and out_ready are both high.
REQ-014 Port overflow, output, 1: one-cycle pulse when an incoming packet is dropped.
REQ-015 Port seq_error, output, 1: one-cycle pulse when a partial packet is abandoned.

Function
REQ-016 The block SHALL hold two packet banks (ping-pong), each 2^LOGSIZE x WIDTH, with a full flag per bank, a write-bank pointer and a read-bank pointer.
REQ-017 The write FSM SHALL have states IDLE, FILL and DISCARD.
REQ-018 In IDLE, a sample with in_index==0 SHALL go to FILL and write slot 0 if the write bank is not full; otherwise it SHALL go to DISCARD and pulse overflow.
REQ-019 In IDLE, a sample with a nonzero in_index SHALL be ignored.
REQ-020 In FILL, a sample with in_index equal to the expected slot SHALL be written, and the expected slot SHALL increment.
REQ-021 In FILL, a frame-end sample SHALL be written, set the bank's full flag, toggle the write-bank pointer and return to IDLE.
REQ-022 In FILL, a sample with in_index==0 (receiver resync) SHALL pulse seq_error and restart the fill at slot 0 of the same bank.
REQ-023 In FILL, any other out-of-order index SHALL pulse seq_error and return to IDLE.
REQ-024 In DISCARD, samples SHALL be ignored; frame end SHALL return to IDLE, and in_index==0 SHALL be re-evaluated as in IDLE.
REQ-025 When LOGSIZE gives one-sample packets (slot 0 is also frame end), REQ-018 and REQ-021 SHALL apply in the same cycle.
REQ-026 out_valid SHALL equal the read bank's full flag; out_data and out_index SHALL be the read bank's slot at the read pointer.
REQ-027 out_last SHALL be high iff out_valid is high and the read pointer is all-ones.
REQ-028 On each transfer the read pointer SHALL increment and wrap to 0.
REQ-029 On the last transfer of a packet, the bank's full flag SHALL be cleared and the read-bank pointer toggled.
REQ-030 Latency: out_valid SHALL rise on the cycle after the frame-end sample.
REQ-031 A commit and a release on the same cycle SHALL both take effect, and the released bank SHALL be immediately writable.
REQ-032 out_data SHALL be held stable while out_valid is high and out_ready is low.

Reset
REQ-033 While reset_n is low, all of the following SHALL be reset: the FSM to IDLE, both full flags, both bank pointers, the read pointer, the expected slot, out_valid, out_last, overflow, seq_error, out_index and out_data to 0, and dropped_count (when present) to 0.
REQ-034 Bank contents SHALL not require reset.
REQ-035 A reset during a fill SHALL discard the partial packet.

Configuration
REQ-036 With RX_PKTBUF_DROP_CNT_EN defined, the block SHALL add output dropped_count (16 bits), incremented on each overflow pulse and saturating at 16'hFFFF.
REQ-037 Without RX_PKTBUF_DROP_CNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-038 The write-FSM state encoding and the dropped_count width constant SHALL live in shared package serial_pkg.
REQ-039 The bank storage with its two pointers and full flags SHALL be sub-module pingpong_bank; the FSM and handshake logic stay in rx_packet_buffer.

Verification (WIDTH=16, LOGSIZE=1)
REQ-040 The bench SHALL cover: samples 16'h1234 (index 0) then 16'h5678 (index 1, frame end), out_ready=1 -> out_valid on the next cycle; transfers 1234/idx0/last=0 then 5678/idx1/last=1.
REQ-041 The bench SHALL cover: three packets with out_ready=0 -> the first two are buffered, the third pulses overflow once, dropped_count=1; after draining, the first two emerge in order.
REQ-042 The bench SHALL cover: index 0 (16'hAAAA), then index 0 (16'hBBBB), then index 1 frame end (16'hCCCC) -> seq_error pulses once; output packet is BBBB, CCCC.
REQ-043 The bench SHALL cover: out_ready toggling 1/0 every cycle during a read -> each word is transferred exactly once, and out_data is stable while stalled.
REQ-044 The bench SHALL cover: a release of the last word on the same cycle as another packet's frame end with both banks in use -> no overflow, both packets delivered intact.
REQ-045 The bench SHALL cover: reset_n asserted after index 0 mid-fill -> out_valid=0, and a subsequent full packet is delivered correctly.
